// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NUM_CH result channels.
// Each granted record is sent as "Rk=NNNNNN,CCCCCC,FF\r\n" one character at a time.
module uart_frame_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned TX_TMO = 16384
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0]      rec_valid,
  output logic [NUM_CH-1:0]      rec_ready,
  input  logic [24*NUM_CH-1:0]   rec_n,
  input  logic [24*NUM_CH-1:0]   rec_coarse,
  input  logic [8*NUM_CH-1:0]    rec_fine,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   frame_active,
  output logic [3:0]             frame_ch,
  output logic [15:0]            frame_cnt,
  output logic                   tx_err
);

  // Counter only has to hold 0..TX_TMO-1.
  localparam int unsigned TmoW = (TX_TMO > 1) ? $clog2(TX_TMO) : 1;
  localparam logic [4:0]  LastIdx = 5'd20;

  typedef enum logic [1:0] {StIdle, StLoad, StStart, StWait} state_e;

  state_e            state_q;
  logic [3:0]        rr_ptr_q;
  logic [4:0]        msg_idx_q;
  logic [TmoW-1:0]   tmo_q;
  logic              tx_busy_q;
  logic [23:0]       n_q;
  logic [23:0]       coarse_q;
  logic [7:0]        fine_q;

  logic [15:0]       valid_pad;
  logic [4:0]        scan_idx;
  logic [3:0]        grant;
  logic              grant_vld;
  logic [23:0]       sel_n;
  logic [23:0]       sel_coarse;
  logic [7:0]        sel_fine;
  logic [7:0]        cur_char;
  logic              tx_done;

  function automatic logic [7:0] hex_char(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
  endfunction

  // First valid channel scanning from rr_ptr upward with wrap.
  always_comb begin
    valid_pad = 16'(rec_valid);
    scan_idx  = '0;
    grant     = '0;
    grant_vld = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + 5'(k);
      if (scan_idx >= 5'(NUM_CH)) begin
        scan_idx = scan_idx - 5'(NUM_CH);
      end
      if (!grant_vld && valid_pad[scan_idx[3:0]]) begin
        grant     = scan_idx[3:0];
        grant_vld = 1'b1;
      end
    end
  end

  // Select the granted channel's record fields for capture in LOAD.
  always_comb begin
    sel_n      = '0;
    sel_coarse = '0;
    sel_fine   = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      if (frame_ch == 4'(ch)) begin
        sel_n      = rec_n[24*ch +: 24];
        sel_coarse = rec_coarse[24*ch +: 24];
        sel_fine   = rec_fine[8*ch +: 8];
      end
    end
  end

  // Frame character for the current message index.
  always_comb begin
    case (msg_idx_q)
      5'd0:    cur_char = 8'h52;
      5'd1:    cur_char = hex_char(frame_ch);
      5'd2:    cur_char = 8'h3D;
      5'd3:    cur_char = hex_char(n_q[23:20]);
      5'd4:    cur_char = hex_char(n_q[19:16]);
      5'd5:    cur_char = hex_char(n_q[15:12]);
      5'd6:    cur_char = hex_char(n_q[11:8]);
      5'd7:    cur_char = hex_char(n_q[7:4]);
      5'd8:    cur_char = hex_char(n_q[3:0]);
      5'd9:    cur_char = 8'h2C;
      5'd10:   cur_char = hex_char(coarse_q[23:20]);
      5'd11:   cur_char = hex_char(coarse_q[19:16]);
      5'd12:   cur_char = hex_char(coarse_q[15:12]);
      5'd13:   cur_char = hex_char(coarse_q[11:8]);
      5'd14:   cur_char = hex_char(coarse_q[7:4]);
      5'd15:   cur_char = hex_char(coarse_q[3:0]);
      5'd16:   cur_char = 8'h2C;
      5'd17:   cur_char = hex_char(fine_q[7:4]);
      5'd18:   cur_char = hex_char(fine_q[3:0]);
      5'd19:   cur_char = 8'h0D;
      default: cur_char = 8'h0A;
    endcase
  end

  // Falling edge of uart busy marks the end of one character.
  assign tx_done = tx_busy_q & ~tx_busy;

  // Arbitration and serialisation FSM; all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      msg_idx_q    <= '0;
      tmo_q        <= '0;
      tx_busy_q    <= 1'b0;
      n_q          <= '0;
      coarse_q     <= '0;
      fine_q       <= '0;
      rec_ready    <= '0;
      tx_data      <= '0;
      tx_start     <= 1'b0;
      frame_active <= 1'b0;
      frame_ch     <= '0;
      frame_cnt    <= '0;
      tx_err       <= 1'b0;
    end else begin
      tx_busy_q <= tx_busy;
      tx_start  <= 1'b0;
      rec_ready <= '0;
      unique case (state_q)
        StIdle: begin
          if (grant_vld) begin
            frame_ch     <= grant;
            frame_active <= 1'b1;
            rec_ready    <= NUM_CH'(1) << grant;
            state_q      <= StLoad;
          end
        end
        StLoad: begin
          n_q       <= sel_n;
          coarse_q  <= sel_coarse;
          fine_q    <= sel_fine;
          rr_ptr_q  <= (frame_ch == 4'(NUM_CH - 1)) ? 4'd0 : frame_ch + 4'd1;
          msg_idx_q <= '0;
          state_q   <= StStart;
        end
        StStart: begin
          tx_data <= cur_char;
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tmo_q    <= '0;
            state_q  <= StWait;
          end
        end
        StWait: begin
          if (tx_done) begin
            if (msg_idx_q == LastIdx) begin
              frame_cnt    <= frame_cnt + 16'd1;
              frame_active <= 1'b0;
              state_q      <= StIdle;
            end else begin
              msg_idx_q <= msg_idx_q + 5'd1;
              state_q   <= StStart;
            end
          end else if (tmo_q == TmoW'(TX_TMO - 1)) begin
            // Abort: the record is dropped, not re-sent.
            tx_err       <= 1'b1;
            frame_active <= 1'b0;
            state_q      <= StIdle;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
